sram_sp_ctrl: RTL and testbench



---
 rtl/sram_sp_ctrl_if.sv | 28 ++
 rtl/sram_sp_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_sp_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_ctrl_if.sv
// Request/response channels between the cache/predictor pipeline and the SRAM controller.
// The pipeline side is the master; the controller is the slave.
interface sram_sp_ctrl_if #(
    parameter int DATA_W = 50,
    parameter int ADDR_W = 7
) ();
    logic              init_done;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        input  init_done, wr_ready, rd_ready, resp_valid, resp_data,
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready
    );

    modport slave (
        output init_done, wr_ready, rd_ready, resp_valid, resp_data,
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready
    );
endinterface

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM initiator: zero-fill sweep, write/read arbitration onto one port,
// and in-order read responses through a bypass path plus a 2-entry skid buffer.
module sram_sp_ctrl #(
    parameter int DATA_W  = 50,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTB,
    sram_sp_ctrl_if.slave     bus,
    output logic              CEB,
    output logic              WEB,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    localparam logic [0:0]        ST_INIT   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [0:0]        ST_RESET  = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] sweep_reg;
    logic              inflight_reg;
    logic [1:0]        count_reg, count_next;
    logic              head_reg;
    logic              rd_last_reg;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;

    logic              run_active, init_active;
    logic              wr_cand, rd_cand, wr_grant, rd_grant;
    logic              bypass_take, push, pop, tail;
    logic [DATA_W-1:0] buf_word [2];

    // RSTB gates the grants so the macro pins fall back to idle the moment reset asserts.
    assign run_active  = RSTB && (state_reg == ST_RUN);
    assign init_active = RSTB && (state_reg == ST_INIT);

    // A read may only launch if its data has a guaranteed slot: buffered + in flight < 2.
    assign wr_cand  = run_active && bus.wr_valid;
    assign rd_cand  = run_active && bus.rd_valid && ((count_reg + {1'b0, inflight_reg}) < 2'd2);
    assign wr_grant = wr_cand && (!rd_cand || rd_last_reg);
    assign rd_grant = rd_cand && !wr_grant;

    assign bus.init_done = run_active;
    assign bus.wr_ready  = wr_grant;
    assign bus.rd_ready  = rd_grant;

    always_comb begin
        CEB = 1'b1;
        WEB = 1'b1;
        A   = a_reg;
        D   = d_reg;
        if (init_active) begin
            CEB = 1'b0;
            WEB = 1'b0;
            A   = sweep_reg;
            D   = '0;
        end else if (wr_grant) begin
            CEB = 1'b0;
            WEB = 1'b0;
            A   = bus.wr_addr;
            D   = bus.wr_data;
        end else if (rd_grant) begin
            CEB = 1'b0;
            A   = bus.rd_addr;
        end
    end

    // Q is consumed directly only when nothing older is buffered; otherwise it queues behind.
    assign bypass_take = inflight_reg && (count_reg == 2'd0) && bus.resp_ready;
    assign push        = inflight_reg && !bypass_take;
    assign pop         = (count_reg != 2'd0) && bus.resp_ready;
    assign tail        = head_reg ^ count_reg[0];
    assign count_next  = count_reg + {1'b0, push} - {1'b0, pop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge CLK) begin
                if (push && (tail == 1'(gi))) begin
                    data_reg <= Q;
                end
            end
            assign buf_word[gi] = data_reg;
        end
    endgenerate

    assign bus.resp_valid = (count_reg != 2'd0) || inflight_reg;
    assign bus.resp_data  = (count_reg != 2'd0) ? buf_word[head_reg] :
                            (inflight_reg ? Q : '0);

    always_comb begin
        state_next = state_reg;
        if ((state_reg == ST_INIT) && (sweep_reg == LAST_ADDR)) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_reg    <= ST_RESET;
            sweep_reg    <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            head_reg     <= 1'b0;
            rd_last_reg  <= 1'b1;
            a_reg        <= '0;
            d_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd_grant;
            count_reg    <= count_next;
            a_reg        <= A;
            d_reg        <= D;
            if (state_reg == ST_INIT) begin
                sweep_reg <= sweep_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            if (wr_grant) begin
                rd_last_reg <= 1'b0;
            end else if (rd_grant) begin
                rd_last_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Bench for sram_sp_ctrl: behavioural SRAM macro, reference memory + response queue,
// directed vector table, hand-written corner sequences and a randomized phase.
module tb_sram_sp_ctrl;
    localparam int DW    = 50;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          CLK  = 1'b0;
    logic          RSTB = 1'b0;
    logic          CEB, WEB;
    logic [AW-1:0] A;
    logic [DW-1:0] D, Q;

    sram_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_sp_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_EN(1'b1)) dut (
        .CLK(CLK), .RSTB(RSTB), .bus(bus.slave),
        .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural macro: garbage-filled at start, Q random except the cycle after a read.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] q_hold, q_junk;
    logic          q_ok   = 1'b0;
    bit            seeded = 1'b0;

    always @(posedge CLK) begin
        q_junk <= DW'({$urandom(), $urandom()});
        q_ok   <= !CEB && WEB;
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] <= DW'({$urandom(), $urandom()}) | DW'(1);
            seeded <= 1'b1;
        end else if (!CEB && !WEB) begin
            mem_m[A] <= D;
        end
        if (!CEB && WEB) q_hold <= mem_m[A];
    end
    assign Q = q_ok ? q_hold : q_junk;

    // Reference: array contents as seen by accepted requests, and the queue of owed responses.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    bit            last_rd = 1'b1;
    int            mq;
    bit            ew, er;

    initial forever begin
        @(negedge CLK);
        #3;
        if (!RSTB) begin
            exp_q.delete();
            last_rd = 1'b1;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else if (bus.init_done) begin
            mq = exp_q.size();
            ew = bus.wr_valid;
            er = bus.rd_valid && (mq < 2);
            if (ew && er) begin
                ew = last_rd;
                er = !last_rd;
            end
            chk("mon_wr_grant", bus.wr_ready == ew, bus.wr_ready, ew);
            chk("mon_rd_grant", bus.rd_ready == er, bus.rd_ready, er);
            chk("mon_resp_valid", bus.resp_valid == (mq > 0), bus.resp_valid, mq);
            if (bus.resp_valid && mq > 0) begin
                chk("mon_resp_data", bus.resp_data == exp_q[0], bus.resp_data, exp_q[0]);
                if (bus.resp_ready) void'(exp_q.pop_front());
            end
            if (bus.wr_ready) begin
                chk("mon_macro_wr", !CEB && !WEB && A == bus.wr_addr && D == bus.wr_data,
                    {CEB, WEB, A}, {2'b00, bus.wr_addr});
                ref_mem[bus.wr_addr] = bus.wr_data;
                last_rd = 1'b0;
            end else if (bus.rd_ready) begin
                chk("mon_macro_rd", !CEB && WEB && A == bus.rd_addr, {CEB, WEB, A}, {2'b01, bus.rd_addr});
                exp_q.push_back(ref_mem[bus.rd_addr]);
                last_rd = 1'b1;
            end else begin
                chk("mon_macro_idle", CEB && WEB, {CEB, WEB}, 2'b11);
            end
        end
    end

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt [10];

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ceb"}, CEB == 1'b1, CEB, 1);
        chk({tag, "_web"}, WEB == 1'b1, WEB, 1);
        chk({tag, "_a"}, A == '0, A, 0);
        chk({tag, "_d"}, D == '0, D, 0);
        chk({tag, "_init_done"}, bus.init_done == 1'b0, bus.init_done, 0);
        chk({tag, "_readies"}, !bus.wr_ready && !bus.rd_ready, {bus.wr_ready, bus.rd_ready}, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid == 1'b0, bus.resp_valid, 0);
    endtask

    // Starts in the first cycle after reset release; returns at cycle DEPTH (+1 time unit).
    task automatic sweep_check(input bit hold_wr);
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = hold_wr;
            #1;
            chk("sweep", !CEB && !WEB && A == AW'(i) && D == '0 && !bus.init_done
                && !bus.wr_ready && !bus.rd_ready, {CEB, WEB, bus.init_done, A}, AW'(i));
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0;
        #1;
        chk("init_done_rise", bus.init_done && CEB, {bus.init_done, CEB}, 2'b11);
    endtask

    logic [DW-1:0] prev_exp;
    bit            prev_rd;
    int            wp, rp;

    initial begin
        vt[0] = '{1'b1, 7'h12, 50'h3_FFFF_0000_1234, '0};
        vt[1] = '{1'b0, 7'h12, '0, 50'h3_FFFF_0000_1234};
        vt[2] = '{1'b0, 7'h05, '0, '0};
        vt[3] = '{1'b1, 7'h7F, {DW{1'b1}}, '0};
        vt[4] = '{1'b0, 7'h7F, '0, {DW{1'b1}}};
        vt[5] = '{1'b1, 7'h00, 50'h2_AAAA_5555_AAAA, '0};
        vt[6] = '{1'b0, 7'h00, '0, 50'h2_AAAA_5555_AAAA};
        vt[7] = '{1'b1, 7'h12, 50'h1, '0};
        vt[8] = '{1'b0, 7'h12, '0, 50'h1};
        vt[9] = '{1'b0, 7'h7F, '0, {DW{1'b1}}};

        bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.resp_ready = 1'b0;
        bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk_reset_outs("reset");
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        @(negedge CLK);
        RSTB = 1'b1;
        sweep_check(1'b0);
        @(negedge CLK);

        // Both requesters pending: W,R,W,R starting write-first.
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
            bus.wr_addr = AW'(8'h30 + k); bus.wr_data = DW'(32'h1000 + k);
            bus.rd_addr = AW'(8'h30 + k - 1);
            #1;
            chk("rr_wr_ready", bus.wr_ready == (k % 2 == 0), bus.wr_ready, (k % 2 == 0));
            chk("rr_rd_ready", bus.rd_ready == (k % 2 == 1), bus.rd_ready, (k % 2 == 1));
            chk("rr_ceb", CEB == 1'b0, CEB, 0);
            if (k == 2) chk("rr_resp0", bus.resp_valid && bus.resp_data == DW'(32'h1000), bus.resp_data, 32'h1000);
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        #1;
        chk("rr_resp1", bus.resp_valid && bus.resp_data == DW'(32'h1002), bus.resp_data, 32'h1002);
        @(negedge CLK);

        // Vector table: one request per cycle, read data due exactly one cycle after grant.
        prev_rd = 1'b0; prev_exp = '0;
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = vt[i].is_wr; bus.rd_valid = !vt[i].is_wr;
            bus.wr_addr = vt[i].addr; bus.rd_addr = vt[i].addr; bus.wr_data = vt[i].data;
            #1;
            chk("vec_grant", vt[i].is_wr ? bus.wr_ready : bus.rd_ready, i, 1);
            chk("vec_resp", bus.resp_valid == prev_rd && (!prev_rd || bus.resp_data == prev_exp),
                bus.resp_data, prev_exp);
            $display("vec %0d %s addr=%0h data=%0h", i, vt[i].is_wr ? "WR" : "RD", vt[i].addr,
                     vt[i].is_wr ? vt[i].data : vt[i].exp);
            prev_rd = !vt[i].is_wr; prev_exp = vt[i].exp;
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        #1;
        chk("vec_resp_last", bus.resp_valid && bus.resp_data == prev_exp, bus.resp_data, prev_exp);
        @(negedge CLK);

        // Backpressure: only two reads outstanding while resp_ready is low.
        for (int k = 1; k <= 3; k++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(k); bus.wr_data = DW'(32'h11111 * k);
            #1;
            chk("bp_wr", bus.wr_ready, bus.wr_ready, 1);
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 7'd1;
        #1; chk("bp_rd1", bus.rd_ready, bus.rd_ready, 1);
        @(negedge CLK);
        bus.rd_addr = 7'd2;
        #1; chk("bp_rd2", bus.rd_ready && bus.resp_valid, {bus.rd_ready, bus.resp_valid}, 2'b11);
        @(negedge CLK);
        bus.rd_addr = 7'd3;
        #1; chk("bp_rd3_blocked", !bus.rd_ready, bus.rd_ready, 0);
        @(negedge CLK);
        #1; chk("bp_full", !bus.rd_ready && bus.resp_valid && bus.resp_data == DW'(32'h11111),
                bus.resp_data, 32'h11111);
        @(negedge CLK);
        bus.resp_ready = 1'b1;
        #1; chk("bp_pop1", !bus.rd_ready && bus.resp_data == DW'(32'h11111), bus.resp_data, 32'h11111);
        @(negedge CLK);
        #1; chk("bp_pop2", bus.rd_ready && bus.resp_data == DW'(32'h22222), bus.resp_data, 32'h22222);
        @(negedge CLK);
        bus.rd_valid = 1'b0;
        #1; chk("bp_rd3_data", bus.resp_valid && bus.resp_data == DW'(32'h33333), bus.resp_data, 32'h33333);
        @(negedge CLK);
        #1; chk("bp_empty", !bus.resp_valid, bus.resp_valid, 0);
        @(negedge CLK);

        // Randomized traffic on a small address window to provoke read-after-write.
        wp = 50; rp = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                wp = $urandom_range(5, 90);
                rp = $urandom_range(5, 90);
            end
            bus.wr_valid   = ($urandom_range(0, 99) < wp);
            bus.rd_valid   = ($urandom_range(0, 99) < rp);
            bus.wr_addr    = AW'($urandom_range(0, 15));
            bus.rd_addr    = AW'($urandom_range(0, 15));
            bus.wr_data    = DW'({$urandom(), $urandom()});
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.resp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge CLK);
            #4;
        end
        chk("drain", exp_q.size() == 0, exp_q.size(), 0);
        @(negedge CLK);

        // Idle RUN with garbage on Q: nothing may be forwarded.
        for (int k = 0; k < 20; k++) begin
            bus.resp_ready = 1'($urandom_range(0, 1));
            #1;
            chk("idle_resp", !bus.resp_valid, bus.resp_valid, 0);
            @(negedge CLK);
        end

        // Reset while a read is in flight: the response is dropped.
        bus.resp_ready = 1'b1; bus.rd_valid = 1'b1; bus.rd_addr = 7'd3;
        #1; chk("inflight_grant", bus.rd_ready, bus.rd_ready, 1);
        @(negedge CLK);
        bus.rd_valid = 1'b0;
        #2; RSTB = 1'b0;
        #1; chk("inflight_drop", !bus.resp_valid && CEB && !bus.init_done,
                {bus.resp_valid, CEB, bus.init_done}, 3'b010);
        @(negedge CLK);
        #1; chk_reset_outs("run_reset");
        @(negedge CLK);
        RSTB = 1'b1;

        // Reset again at sweep address 60; sweep must restart from 0.
        for (int i = 0; i <= 60; i++) begin
            #1;
            chk("sweep_partial", !CEB && !WEB && A == AW'(i), {CEB, WEB, A}, AW'(i));
            if (i < 60) @(negedge CLK);
        end
        #1; RSTB = 1'b0;
        #1; chk_reset_outs("mid_sweep");
        @(negedge CLK);
        @(negedge CLK);
        RSTB = 1'b1;
        sweep_check(1'b1);
        @(negedge CLK);

        bus.rd_valid = 1'b1; bus.rd_addr = 7'h12;
        #1; chk("refill_rd_grant", bus.rd_ready, bus.rd_ready, 1);
        @(negedge CLK);
        bus.rd_valid = 1'b0;
        #1; chk("refill_zero", bus.resp_valid && bus.resp_data == '0, bus.resp_data, 0);
        @(negedge CLK);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=finish", checks);
        $fatal(1, "timeout");
    end
endmodule
